// File: rtl/sysbus_pkg.sv
// sysbus_pkg
// Shared definitions for the instruction/data cache system-bus arbiter:
// arbiter state encoding, owner identity, and the bus tag field layout
// (read/write bit and device field) with their constant values.
package sysbus_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWN_IC = 2'd1,
        ARB_OWN_DC = 2'd2,
        ARB_DRAIN  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_ICACHE = 1'b0,
        OWNER_DCACHE = 1'b1
    } owner_e;

    // Tag layout: bit 12 = read/write, bits 11:8 = target device.
    localparam int TAG_RW_BIT  = 12;
    localparam int TAG_DEV_MSB = 11;
    localparam int TAG_DEV_LSB = 8;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    function automatic logic tag_is_read(input logic rw_bit);
        return rw_bit == SYSBUS_READ;
    endfunction

endpackage

// File: rtl/sysbus_route_mux.sv
// sysbus_route_mux
// Purely combinational owner-select mux between the two cache clients and
// the system bus, for both the request and the response direction.
// Ports:
//   route_ic_req / route_dc_req   : forward that client's request channel
//   route_ic_resp / route_dc_resp : return bus responses to that client
//   ic_* / dc_* client inputs     : reqcyc, req, reqtag, respack
//   bus_* bus inputs              : reqack, respcyc, resp, resptag
//   bus_* outputs                 : reqcyc, req, reqtag, respack
//   ic_* / dc_* client outputs    : reqack, respcyc, resp, resptag
// Every output is zero when its direction is not routed.
import sysbus_pkg::*;

module sysbus_route_mux #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13
) (
    input  logic                      route_ic_req,
    input  logic                      route_dc_req,
    input  logic                      route_ic_resp,
    input  logic                      route_dc_resp,

    input  logic                      ic_bus_reqcyc,
    input  logic                      ic_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] ic_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_bus_reqtag,
    input  logic                      dc_bus_reqcyc,
    input  logic                      dc_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] dc_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_bus_reqtag,

    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,

    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,

    output logic                      ic_bus_reqack,
    output logic                      ic_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ic_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_bus_resptag,
    output logic                      dc_bus_reqack,
    output logic                      dc_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dc_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dc_bus_resptag
);

    always_comb begin
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        bus_reqtag = '0;
        if (route_ic_req) begin
            bus_reqcyc = ic_bus_reqcyc;
            bus_req    = ic_bus_req;
            bus_reqtag = ic_bus_reqtag;
        end else if (route_dc_req) begin
            bus_reqcyc = dc_bus_reqcyc;
            bus_req    = dc_bus_req;
            bus_reqtag = dc_bus_reqtag;
        end
    end

    assign bus_respack = (route_ic_resp & ic_bus_respack) |
                         (route_dc_resp & dc_bus_respack);

    assign ic_bus_reqack  = route_ic_req & bus_reqack;
    assign dc_bus_reqack  = route_dc_req & bus_reqack;

    assign ic_bus_respcyc = route_ic_resp & bus_respcyc;
    assign ic_bus_resp    = route_ic_resp ? bus_resp    : '0;
    assign ic_bus_resptag = route_ic_resp ? bus_resptag : '0;
    assign dc_bus_respcyc = route_dc_resp & bus_respcyc;
    assign dc_bus_resp    = route_dc_resp ? bus_resp    : '0;
    assign dc_bus_resptag = route_dc_resp ? bus_resptag : '0;

endmodule

// File: rtl/sysbus_arbiter.sv
// sysbus_arbiter
// Two-client arbiter giving the instruction cache or the data cache
// exclusive ownership of the single system bus. The grant is held until
// the owner drops its assert and all read-response beats have drained.
// Ports:
//   clk, reset (synchronous, active high)
//   ic_/dc_bus_assert, _reqcyc, _respack, _req, _reqtag : client inputs
//   ic_/dc_has_bus (registered grant), _reqack, _respcyc, _resp, _resptag
//   bus_reqcyc, bus_respack, bus_req, bus_reqtag : to the system bus
//   bus_reqack, bus_respcyc, bus_resp, bus_resptag : from the system bus
// Build option: define SYSBUS_ARB_DC_PRIORITY_EN to make the data cache
// win every simultaneous request in IDLE; otherwise ties alternate.
//
// state      | meaning
// ARB_IDLE   | no owner, nothing forwarded, arbitrate asserts
// ARB_OWN_IC | icache owns the bus, both directions routed to it
// ARB_OWN_DC | dcache owns the bus, both directions routed to it
// ARB_DRAIN  | owner released; requests blocked, remaining read beats
//            | still returned to last_owner
import sysbus_pkg::*;

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_bus_assert,
    input  logic                      dc_bus_assert,
    input  logic                      ic_bus_reqcyc,
    input  logic                      dc_bus_reqcyc,
    input  logic                      ic_bus_respack,
    input  logic                      dc_bus_respack,
    input  logic [BUS_DATA_WIDTH-1:0] ic_bus_req,
    input  logic [BUS_DATA_WIDTH-1:0] dc_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_bus_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_bus_reqtag,

    output logic                      ic_has_bus,
    output logic                      dc_has_bus,
    output logic                      ic_bus_reqack,
    output logic                      dc_bus_reqack,
    output logic                      ic_bus_respcyc,
    output logic                      dc_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ic_bus_resp,
    output logic [BUS_DATA_WIDTH-1:0] dc_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_bus_resptag,
    output logic [BUS_TAG_WIDTH-1:0]  dc_bus_resptag,

    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int CNT_W = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS);

    arb_state_e       state, state_next;
    owner_e           last_owner, last_owner_next;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_next, beat_cnt_dec;
    logic             ic_has_bus_q, dc_has_bus_q;

    logic route_ic_req, route_dc_req, route_ic_resp, route_dc_resp;
    logic owner_assert, read_accept;

    // Routing depends on registered state only, so the mux outputs never
    // feed back into the routing decision within a cycle.
    always_comb begin
        route_ic_req  = 1'b0;
        route_dc_req  = 1'b0;
        route_ic_resp = 1'b0;
        route_dc_resp = 1'b0;
        case (state)
            ARB_OWN_IC: begin
                route_ic_req  = 1'b1;
                route_ic_resp = 1'b1;
            end
            ARB_OWN_DC: begin
                route_dc_req  = 1'b1;
                route_dc_resp = 1'b1;
            end
            ARB_DRAIN: begin
                route_ic_resp = (last_owner == OWNER_ICACHE);
                route_dc_resp = (last_owner == OWNER_DCACHE);
            end
            default: ;
        endcase
    end

    sysbus_route_mux #(
        .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
        .BUS_TAG_WIDTH  (BUS_TAG_WIDTH)
    ) u_route_mux (
        .route_ic_req   (route_ic_req),
        .route_dc_req   (route_dc_req),
        .route_ic_resp  (route_ic_resp),
        .route_dc_resp  (route_dc_resp),
        .ic_bus_reqcyc  (ic_bus_reqcyc),
        .ic_bus_respack (ic_bus_respack),
        .ic_bus_req     (ic_bus_req),
        .ic_bus_reqtag  (ic_bus_reqtag),
        .dc_bus_reqcyc  (dc_bus_reqcyc),
        .dc_bus_respack (dc_bus_respack),
        .dc_bus_req     (dc_bus_req),
        .dc_bus_reqtag  (dc_bus_reqtag),
        .bus_reqack     (bus_reqack),
        .bus_respcyc    (bus_respcyc),
        .bus_resp       (bus_resp),
        .bus_resptag    (bus_resptag),
        .bus_reqcyc     (bus_reqcyc),
        .bus_respack    (bus_respack),
        .bus_req        (bus_req),
        .bus_reqtag     (bus_reqtag),
        .ic_bus_reqack  (ic_bus_reqack),
        .ic_bus_respcyc (ic_bus_respcyc),
        .ic_bus_resp    (ic_bus_resp),
        .ic_bus_resptag (ic_bus_resptag),
        .dc_bus_reqack  (dc_bus_reqack),
        .dc_bus_respcyc (dc_bus_respcyc),
        .dc_bus_resp    (dc_bus_resp),
        .dc_bus_resptag (dc_bus_resptag)
    );

    assign read_accept  = bus_reqcyc & bus_reqack &
                          tag_is_read(bus_reqtag[TAG_RW_BIT]);
    assign owner_assert = (state == ARB_OWN_IC) ? ic_bus_assert : dc_bus_assert;
    assign beat_cnt_dec = (beat_cnt != '0) ? beat_cnt - CNT_W'(1) : '0;

    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        beat_cnt_next   = beat_cnt;
        case (state)
            ARB_IDLE: begin
                if (ic_bus_assert && dc_bus_assert) begin
`ifdef SYSBUS_ARB_DC_PRIORITY_EN
                    state_next = ARB_OWN_DC;
`else
                    state_next = (last_owner == OWNER_DCACHE) ? ARB_OWN_IC : ARB_OWN_DC;
`endif
                end else if (ic_bus_assert) begin
                    state_next = ARB_OWN_IC;
                end else if (dc_bus_assert) begin
                    state_next = ARB_OWN_DC;
                end
            end
            ARB_OWN_IC, ARB_OWN_DC: begin
                if (read_accept)
                    beat_cnt_next = CNT_LOAD;
                else if (bus_respcyc)
                    beat_cnt_next = beat_cnt_dec;
                // Release decision uses the post-update count so a drop
                // coinciding with the final beat goes straight to IDLE.
                if (!owner_assert) begin
                    last_owner_next = (state == ARB_OWN_IC) ? OWNER_ICACHE : OWNER_DCACHE;
                    state_next      = (beat_cnt_next == '0) ? ARB_IDLE : ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                if (bus_respcyc)
                    beat_cnt_next = beat_cnt_dec;
                if (beat_cnt_next == '0)
                    state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            last_owner   <= OWNER_DCACHE;
            beat_cnt     <= '0;
            ic_has_bus_q <= 1'b0;
            dc_has_bus_q <= 1'b0;
        end else begin
            state        <= state_next;
            last_owner   <= last_owner_next;
            beat_cnt     <= beat_cnt_next;
            ic_has_bus_q <= (state_next == ARB_OWN_IC);
            dc_has_bus_q <= (state_next == ARB_OWN_DC);
        end
    end

    assign ic_has_bus = ic_has_bus_q;
    assign dc_has_bus = dc_has_bus_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
module tb_sysbus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;
`ifdef SYSBUS_ARB_DC_PRIORITY_EN
    localparam bit DC_PRIO = 1'b1;
`else
    localparam bit DC_PRIO = 1'b0;
`endif
    localparam logic [TW-1:0] TAG_RD = 13'h1100;
    localparam logic [TW-1:0] TAG_WR = 13'h0100;

    logic          clk = 1'b0;
    logic          reset;
    logic          ic_bus_assert, dc_bus_assert;
    logic          ic_bus_reqcyc, dc_bus_reqcyc;
    logic          ic_bus_respack, dc_bus_respack;
    logic [DW-1:0] ic_bus_req, dc_bus_req;
    logic [TW-1:0] ic_bus_reqtag, dc_bus_reqtag;
    logic          ic_has_bus, dc_has_bus;
    logic          ic_bus_reqack, dc_bus_reqack;
    logic          ic_bus_respcyc, dc_bus_respcyc;
    logic [DW-1:0] ic_bus_resp, dc_bus_resp;
    logic [TW-1:0] ic_bus_resptag, dc_bus_resptag;
    logic          bus_reqcyc, bus_respack;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack, bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_ic;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(8)) dut (
        .clk(clk), .reset(reset),
        .ic_bus_assert(ic_bus_assert), .dc_bus_assert(dc_bus_assert),
        .ic_bus_reqcyc(ic_bus_reqcyc), .dc_bus_reqcyc(dc_bus_reqcyc),
        .ic_bus_respack(ic_bus_respack), .dc_bus_respack(dc_bus_respack),
        .ic_bus_req(ic_bus_req), .dc_bus_req(dc_bus_req),
        .ic_bus_reqtag(ic_bus_reqtag), .dc_bus_reqtag(dc_bus_reqtag),
        .ic_has_bus(ic_has_bus), .dc_has_bus(dc_has_bus),
        .ic_bus_reqack(ic_bus_reqack), .dc_bus_reqack(dc_bus_reqack),
        .ic_bus_respcyc(ic_bus_respcyc), .dc_bus_respcyc(dc_bus_respcyc),
        .ic_bus_resp(ic_bus_resp), .dc_bus_resp(dc_bus_resp),
        .ic_bus_resptag(ic_bus_resptag), .dc_bus_resptag(dc_bus_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_bus_assert = 0; dc_bus_assert = 0;
        ic_bus_reqcyc = 0; dc_bus_reqcyc = 0;
        ic_bus_respack = 0; dc_bus_respack = 0;
        ic_bus_req = '0; dc_bus_req = '0;
        ic_bus_reqtag = '0; dc_bus_reqtag = '0;
        bus_reqack = 0; bus_respcyc = 0;
        bus_resp = '0; bus_resptag = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_checks++; if (ic_has_bus !== 1'b0) begin n_fail++; $display("FAIL rst_ic_has_bus: got %b want 0", ic_has_bus); end
        n_checks++; if (dc_has_bus !== 1'b0) begin n_fail++; $display("FAIL rst_dc_has_bus: got %b want 0", dc_has_bus); end
        dc_bus_reqcyc = 1; bus_respcyc = 1; bus_resp = 64'hFF; dc_bus_respack = 1;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL idle_bus_reqcyc: got %b want 0", bus_reqcyc); end
        n_checks++; if (bus_respack !== 1'b0) begin n_fail++; $display("FAIL idle_bus_respack: got %b want 0", bus_respack); end
        n_checks++; if (dc_bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL idle_dc_respcyc: got %b want 0", dc_bus_respcyc); end
        n_checks++; if (ic_bus_resp !== 64'h0) begin n_fail++; $display("FAIL idle_ic_resp: got %h want 0", ic_bus_resp); end
        clear_inputs();
    endtask

    task automatic test_round_robin();
        exp_ic = !DC_PRIO;
        ic_bus_assert = 1; dc_bus_assert = 1;
        step();
        n_checks++; if (ic_has_bus !== exp_ic) begin n_fail++; $display("FAIL tie1_ic: got %b want %b", ic_has_bus, exp_ic); end
        n_checks++; if (dc_has_bus !== !exp_ic) begin n_fail++; $display("FAIL tie1_dc: got %b want %b", dc_has_bus, !exp_ic); end
        if (exp_ic) ic_bus_assert = 0; else dc_bus_assert = 0;
        step();
        n_checks++; if ({ic_has_bus, dc_has_bus} !== 2'b00) begin n_fail++; $display("FAIL rr_idle_gap: got %b want 00", {ic_has_bus, dc_has_bus}); end
        step();
        n_checks++; if (ic_has_bus !== !exp_ic || dc_has_bus !== exp_ic) begin n_fail++; $display("FAIL rr_second: got ic=%b dc=%b want ic=%b", ic_has_bus, dc_has_bus, !exp_ic); end
        ic_bus_assert = 0; dc_bus_assert = 0;
        step();
        ic_bus_assert = 1; dc_bus_assert = 1;
        step();
        n_checks++; if (ic_has_bus !== exp_ic) begin n_fail++; $display("FAIL tie2_ic: got %b want %b", ic_has_bus, exp_ic); end
        ic_bus_assert = 0; dc_bus_assert = 0;
        step();
        ic_bus_assert = 1; dc_bus_assert = 1;
        step();
        n_checks++; if (dc_has_bus !== 1'b1 || ic_has_bus !== 1'b0) begin n_fail++; $display("FAIL tie3_dc: got ic=%b dc=%b want ic=0 dc=1", ic_has_bus, dc_has_bus); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_dc_read();
        dc_bus_assert = 1; dc_bus_reqcyc = 1; dc_bus_req = 64'hA0; dc_bus_reqtag = TAG_RD;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b0) begin n_fail++; $display("FAIL rd_idle_fwd: got %b want 0", bus_reqcyc); end
        step();
        n_checks++; if (dc_has_bus !== 1'b1 || ic_has_bus !== 1'b0) begin n_fail++; $display("FAIL rd_grant: got ic=%b dc=%b want ic=0 dc=1", ic_has_bus, dc_has_bus); end
        bus_reqack = 1;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'hA0 || bus_reqtag !== TAG_RD) begin n_fail++; $display("FAIL rd_fwd: got cyc=%b req=%h tag=%h want 1/a0/1100", bus_reqcyc, bus_req, bus_reqtag); end
        n_checks++; if (dc_bus_reqack !== 1'b1 || ic_bus_reqack !== 1'b0) begin n_fail++; $display("FAIL rd_reqack: got ic=%b dc=%b want ic=0 dc=1", ic_bus_reqack, dc_bus_reqack); end
        step();
        dc_bus_reqcyc = 0; bus_reqack = 0;
        for (int i = 0; i < 8; i++) begin
            bus_respcyc = 1; bus_resp = 64'h1000 + 64'(i); bus_resptag = TAG_RD; dc_bus_respack = 1;
            if (i == 7) begin dc_bus_assert = 0; ic_bus_assert = 1; end
            #1;
            n_checks++; if (dc_bus_respcyc !== 1'b1 || dc_bus_resp !== 64'h1000 + 64'(i) || dc_bus_resptag !== TAG_RD) begin n_fail++; $display("FAIL rd_beat%0d: got cyc=%b data=%h tag=%h", i, dc_bus_respcyc, dc_bus_resp, dc_bus_resptag); end
            n_checks++; if (ic_bus_respcyc !== 1'b0 || ic_bus_resp !== 64'h0) begin n_fail++; $display("FAIL rd_ic_quiet%0d: got cyc=%b data=%h want 0", i, ic_bus_respcyc, ic_bus_resp); end
            n_checks++; if (bus_respack !== 1'b1) begin n_fail++; $display("FAIL rd_respack%0d: got %b want 1", i, bus_respack); end
            step();
        end
        bus_respcyc = 0; dc_bus_respack = 0;
        n_checks++; if ({ic_has_bus, dc_has_bus} !== 2'b00) begin n_fail++; $display("FAIL rd_release: got %b want 00", {ic_has_bus, dc_has_bus}); end
        step();
        n_checks++; if (ic_has_bus !== 1'b1) begin n_fail++; $display("FAIL rd_direct_idle: ic_has_bus=%b want 1", ic_has_bus); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_drain();
        dc_bus_assert = 1;
        step();
        dc_bus_reqcyc = 1; dc_bus_reqtag = TAG_RD; bus_reqack = 1;
        step();
        dc_bus_reqcyc = 0; bus_reqack = 0;
        for (int i = 1; i <= 3; i++) begin
            bus_respcyc = 1; bus_resp = 64'h2000 + 64'(i);
            step();
        end
        bus_respcyc = 0; dc_bus_assert = 0; ic_bus_assert = 1;
        step();
        n_checks++; if ({ic_has_bus, dc_has_bus} !== 2'b00) begin n_fail++; $display("FAIL dr_release: got %b want 00", {ic_has_bus, dc_has_bus}); end
        dc_bus_reqcyc = 1; ic_bus_reqcyc = 1; bus_reqack = 1;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b0 || dc_bus_reqack !== 1'b0) begin n_fail++; $display("FAIL dr_req_blocked: got cyc=%b ack=%b want 0/0", bus_reqcyc, dc_bus_reqack); end
        dc_bus_reqcyc = 0; ic_bus_reqcyc = 0; bus_reqack = 0;
        for (int i = 4; i <= 8; i++) begin
            bus_respcyc = 1; bus_resp = 64'h2000 + 64'(i); dc_bus_respack = 1;
            #1;
            n_checks++; if (dc_bus_respcyc !== 1'b1 || dc_bus_resp !== 64'h2000 + 64'(i)) begin n_fail++; $display("FAIL dr_beat%0d: got cyc=%b data=%h", i, dc_bus_respcyc, dc_bus_resp); end
            n_checks++; if (ic_bus_respcyc !== 1'b0 || ic_has_bus !== 1'b0) begin n_fail++; $display("FAIL dr_ic_wait%0d: got respcyc=%b has_bus=%b want 0/0", i, ic_bus_respcyc, ic_has_bus); end
            n_checks++; if (bus_respack !== 1'b1) begin n_fail++; $display("FAIL dr_respack%0d: got %b want 1", i, bus_respack); end
            step();
        end
        bus_respcyc = 0; dc_bus_respack = 0;
        n_checks++; if (ic_has_bus !== 1'b0) begin n_fail++; $display("FAIL dr_idle_gap: ic_has_bus=%b want 0", ic_has_bus); end
        step();
        n_checks++; if (ic_has_bus !== 1'b1) begin n_fail++; $display("FAIL dr_ic_grant: ic_has_bus=%b want 1", ic_has_bus); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_non_owner();
        dc_bus_assert = 1;
        step();
        ic_bus_assert = 1; ic_bus_reqcyc = 1; ic_bus_req = 64'h55; ic_bus_reqtag = TAG_RD; bus_reqack = 1;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b0 || bus_req !== 64'h0) begin n_fail++; $display("FAIL no_ic_fwd: got cyc=%b req=%h want 0/0", bus_reqcyc, bus_req); end
        n_checks++; if (ic_bus_reqack !== 1'b0) begin n_fail++; $display("FAIL no_ic_ack: got %b want 0", ic_bus_reqack); end
        dc_bus_reqcyc = 1; dc_bus_req = 64'h77; dc_bus_reqtag = TAG_WR;
        #1;
        n_checks++; if (bus_reqcyc !== 1'b1 || bus_req !== 64'h77 || bus_reqtag !== TAG_WR) begin n_fail++; $display("FAIL no_dc_fwd: got cyc=%b req=%h tag=%h want 1/77/0100", bus_reqcyc, bus_req, bus_reqtag); end
        n_checks++; if (ic_bus_reqack !== 1'b0 || dc_bus_reqack !== 1'b1) begin n_fail++; $display("FAIL no_acks: got ic=%b dc=%b want 0/1", ic_bus_reqack, dc_bus_reqack); end
        step();
        n_checks++; if (ic_has_bus !== 1'b0 || dc_has_bus !== 1'b1) begin n_fail++; $display("FAIL no_hold: got ic=%b dc=%b want 0/1", ic_has_bus, dc_has_bus); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_write();
        dc_bus_assert = 1;
        step();
        for (int i = 0; i < 8; i++) begin
            dc_bus_reqcyc = 1; dc_bus_reqtag = TAG_WR; dc_bus_req = 64'h3000 + 64'(i); bus_reqack = 1;
            step();
        end
        dc_bus_reqcyc = 0; bus_reqack = 0;
        bus_respcyc = 1; bus_resp = 64'hBEEF; bus_resptag = TAG_WR;
        #1;
        n_checks++; if (dc_bus_respcyc !== 1'b1 || dc_bus_resp !== 64'hBEEF) begin n_fail++; $display("FAIL wr_resp_cnt0: got cyc=%b data=%h want 1/beef", dc_bus_respcyc, dc_bus_resp); end
        bus_respcyc = 0; dc_bus_assert = 0; ic_bus_assert = 1;
        step();
        n_checks++; if (dc_has_bus !== 1'b0) begin n_fail++; $display("FAIL wr_release: dc_has_bus=%b want 0", dc_has_bus); end
        step();
        n_checks++; if (ic_has_bus !== 1'b1) begin n_fail++; $display("FAIL wr_no_drain: ic_has_bus=%b want 1", ic_has_bus); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_reset_mid();
        dc_bus_assert = 1;
        step();
        dc_bus_reqcyc = 1; dc_bus_reqtag = TAG_RD; bus_reqack = 1;
        step();
        dc_bus_reqcyc = 0; bus_reqack = 0;
        for (int i = 1; i <= 4; i++) begin
            bus_respcyc = 1; bus_resp = 64'h4000 + 64'(i);
            step();
        end
        bus_resp = 64'h4005; reset = 1;
        step();
        reset = 0; dc_bus_reqcyc = 1; dc_bus_respack = 1;
        #1;
        n_checks++; if ({ic_has_bus, dc_has_bus} !== 2'b00) begin n_fail++; $display("FAIL rm_grants: got %b want 00", {ic_has_bus, dc_has_bus}); end
        n_checks++; if (bus_reqcyc !== 1'b0 || bus_respack !== 1'b0) begin n_fail++; $display("FAIL rm_bus_out: got cyc=%b ack=%b want 0/0", bus_reqcyc, bus_respack); end
        n_checks++; if (dc_bus_respcyc !== 1'b0 || dc_bus_resp !== 64'h0 || ic_bus_respcyc !== 1'b0) begin n_fail++; $display("FAIL rm_client_out: got dc=%b data=%h ic=%b want 0", dc_bus_respcyc, dc_bus_resp, ic_bus_respcyc); end
        bus_respcyc = 0; dc_bus_respack = 0;
        step();
        n_checks++; if (dc_has_bus !== 1'b1) begin n_fail++; $display("FAIL rm_regrant: dc_has_bus=%b want 1", dc_has_bus); end
        n_checks++; if (bus_reqcyc !== 1'b1) begin n_fail++; $display("FAIL rm_fwd: bus_reqcyc=%b want 1", bus_reqcyc); end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_dc_read();
        test_drain();
        test_non_owner();
        test_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
